// File: rtl/mips_debug_loader.sv
// UART-driven program loader and run controller for the MIPS core.
// Define DBG_DUMP_EN to stream the halted PC (LSB first) back over UART TX.
module mips_debug_loader #(
  parameter int NBITS    = 32,
  parameter int CELDAS_M = 70,
  parameter int ADDRBITS = 7
) (
  input  logic                basys_clk,
  input  logic                basys_reset,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_done,
  input  logic                i_cpu_halt,
  input  logic [NBITS-1:0]    i_cpu_pc,
  input  logic                i_tx_done,
  output logic                o_im_wr_en,
  output logic [ADDRBITS-1:0] o_im_addr,
  output logic [NBITS-1:0]    o_im_wr_data,
  output logic                o_cpu_en,
  output logic                o_cpu_rst,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_start,
  output logic [2:0]          o_state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_CNT   = 3'd1,
    LOAD_BYTE  = 3'd2,
    LOAD_WRITE = 3'd3,
    RUN        = 3'd4,
    STEP       = 3'd5,
    HALTED     = 3'd6,
    DUMP       = 3'd7
  } state_t;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;
  localparam logic [7:0] CMD_CONT  = 8'h43;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_RST   = 8'h52;
  localparam logic [7:0] CMD_PAUSE = 8'h50;
  localparam logic [7:0] MAX_WORDS = 8'(CELDAS_M);

  state_t              state_r, state_s;
  logic [7:0]          word_cnt_r, word_cnt_s;
  logic [7:0]          word_idx_r, word_idx_s;
  logic [1:0]          byte_cnt_r, byte_cnt_s;
  logic [NBITS-1:0]    word_r, word_s;
  logic                im_wr_en_r, im_wr_en_s;
  logic [ADDRBITS-1:0] im_addr_r, im_addr_s;
  logic [NBITS-1:0]    im_wr_data_r, im_wr_data_s;
  logic                cpu_en_r, cpu_en_s;
  logic                cpu_rst_r, cpu_rst_s;
  logic [7:0]          tx_data_r, tx_data_s;
  logic                tx_start_r, tx_start_s;
  logic                enter_halt_s;
`ifdef DBG_DUMP_EN
  logic [NBITS-1:0]    pc_r, pc_s;
`else
  logic                dump_unused_s;
  assign dump_unused_s = ^{i_cpu_pc, i_tx_done};
`endif

  // Next-state and next-output decode; outputs are strobes unless set here.
  always_comb begin
    state_s      = state_r;
    word_cnt_s   = word_cnt_r;
    word_idx_s   = word_idx_r;
    byte_cnt_s   = byte_cnt_r;
    word_s       = word_r;
    im_wr_en_s   = 1'b0;
    im_addr_s    = im_addr_r;
    im_wr_data_s = im_wr_data_r;
    cpu_en_s     = 1'b0;
    cpu_rst_s    = 1'b0;
    tx_data_s    = tx_data_r;
    tx_start_s   = 1'b0;
    enter_halt_s = 1'b0;
`ifdef DBG_DUMP_EN
    pc_s         = pc_r;
`endif
    case (state_r)
      IDLE: begin
        if (i_rx_done) begin
          case (i_rx_data)
            CMD_LOAD: state_s = LOAD_CNT;
            CMD_CONT: begin state_s = RUN;  cpu_en_s = 1'b1; end
            CMD_STEP: begin state_s = STEP; cpu_en_s = 1'b1; end
            CMD_RST:  cpu_rst_s = 1'b1;
            default:  state_s = IDLE;
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      LOAD_CNT: begin
        if (!i_rx_done) begin
          state_s = LOAD_CNT;
        end else if (i_rx_data == 8'd0) begin
          state_s = IDLE;
        end else begin
          word_cnt_s = (i_rx_data > MAX_WORDS) ? MAX_WORDS : i_rx_data;
          word_idx_s = 8'd0;
          byte_cnt_s = 2'd0;
          state_s    = LOAD_BYTE;
        end
      end
      LOAD_BYTE: begin
        if (i_rx_done) begin
          // Shift in from the top so the first byte ends up in [7:0].
          word_s = {i_rx_data, word_r[NBITS-1:8]};
          if (byte_cnt_r == 2'd3) begin
            byte_cnt_s   = 2'd0;
            im_wr_en_s   = 1'b1;
            im_addr_s    = ADDRBITS'(word_idx_r);
            im_wr_data_s = word_s;
            state_s      = LOAD_WRITE;
          end else begin
            byte_cnt_s = byte_cnt_r + 2'd1;
          end
        end else begin
          state_s = LOAD_BYTE;
        end
      end
      LOAD_WRITE: begin
        word_idx_s = word_idx_r + 8'd1;
        if (word_idx_s == word_cnt_r) begin
          state_s   = IDLE;
          cpu_rst_s = 1'b1;
        end else begin
          state_s = LOAD_BYTE;
        end
      end
      RUN: begin
        if (i_cpu_halt) begin
          enter_halt_s = 1'b1;
        end else if (i_rx_done && (i_rx_data == CMD_PAUSE)) begin
          state_s = IDLE;
        end else begin
          cpu_en_s = 1'b1;
        end
      end
      STEP: begin
        if (i_cpu_halt) begin
          enter_halt_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      HALTED: begin
        if (i_rx_done) begin
          case (i_rx_data)
            CMD_RST:  begin state_s = IDLE; cpu_rst_s = 1'b1; end
            CMD_LOAD: state_s = LOAD_CNT;
            default:  state_s = HALTED;
          endcase
        end else begin
          state_s = HALTED;
        end
      end
      DUMP: begin
`ifdef DBG_DUMP_EN
        if (i_tx_done) begin
          if (byte_cnt_r == 2'd3) begin
            state_s = HALTED;
          end else begin
            byte_cnt_s = byte_cnt_r + 2'd1;
            tx_data_s  = 8'(pc_r >> {byte_cnt_s, 3'b000});
            tx_start_s = 1'b1;
          end
        end else begin
          state_s = DUMP;
        end
`else
        state_s = IDLE;
`endif
      end
      default: state_s = IDLE;
    endcase

    // Halt detection: PC is captured on the same edge the halt is seen.
    if (enter_halt_s) begin
`ifdef DBG_DUMP_EN
      state_s    = DUMP;
      pc_s       = i_cpu_pc;
      byte_cnt_s = 2'd0;
      tx_data_s  = i_cpu_pc[7:0];
      tx_start_s = 1'b1;
`else
      state_s    = HALTED;
`endif
    end else begin
      cpu_rst_s = cpu_rst_s & ~cpu_en_s;
    end
  end

  // State and registered-output update.
  always_ff @(posedge basys_clk or negedge basys_reset) begin
    if (!basys_reset) begin
      state_r      <= IDLE;
      word_cnt_r   <= 8'd0;
      word_idx_r   <= 8'd0;
      byte_cnt_r   <= 2'd0;
      word_r       <= '0;
      im_wr_en_r   <= 1'b0;
      im_addr_r    <= '0;
      im_wr_data_r <= '0;
      cpu_en_r     <= 1'b0;
      cpu_rst_r    <= 1'b0;
      tx_data_r    <= 8'd0;
      tx_start_r   <= 1'b0;
`ifdef DBG_DUMP_EN
      pc_r         <= '0;
`endif
    end else begin
      state_r      <= state_s;
      word_cnt_r   <= word_cnt_s;
      word_idx_r   <= word_idx_s;
      byte_cnt_r   <= byte_cnt_s;
      word_r       <= word_s;
      im_wr_en_r   <= im_wr_en_s;
      im_addr_r    <= im_addr_s;
      im_wr_data_r <= im_wr_data_s;
      cpu_en_r     <= cpu_en_s;
      cpu_rst_r    <= cpu_rst_s;
      tx_data_r    <= tx_data_s;
      tx_start_r   <= tx_start_s;
`ifdef DBG_DUMP_EN
      pc_r         <= pc_s;
`endif
    end
  end

  assign o_im_wr_en   = im_wr_en_r;
  assign o_im_addr    = im_addr_r;
  assign o_im_wr_data = im_wr_data_r;
  assign o_cpu_en     = cpu_en_r;
  assign o_cpu_rst    = cpu_rst_r;
  assign o_tx_data    = tx_data_r;
  assign o_tx_start   = tx_start_r;
  assign o_state      = state_r;

endmodule

// File: doc/mips_debug_loader.md
Name: mips_debug_loader

Overview:
- UART-driven program loader and run controller sitting directly upstream of the MIPS core top.
- Consumes received bytes from the UART RX stage and assembles 32-bit instruction words, writing them into the core's instruction memory.
- Drives the core's enable and reset: continuous run, single-step, and halt detection.
- Optionally dumps the halted PC back over UART TX.

Parameters:
- NBITS, 32: instruction/PC width.
- CELDAS_M, 70: instruction memory depth in words.
- ADDRBITS, 7: instruction memory address width; must satisfy 2^ADDRBITS >= CELDAS_M.

Ports:
- basys_clk  input  1  system clock, rising edge.
- basys_reset  input  1  asynchronous reset, active-low.
- i_rx_data  input  8  received byte, valid when i_rx_done=1.
- i_rx_done  input  1  one-cycle strobe per received byte.
- i_cpu_halt  input  1  core has retired HALT; level.
- i_cpu_pc  input  NBITS  core current PC.
- i_tx_done  input  1  one-cycle strobe, TX byte finished.
- o_im_wr_en  output  1  instruction memory write strobe.
- o_im_addr  output  ADDRBITS  instruction memory word address.
- o_im_wr_data  output  NBITS  instruction word.
- o_cpu_en  output  1  core clock-enable.
- o_cpu_rst  output  1  core reset pulse, active-high.
- o_tx_data  output  8  byte to transmit.
- o_tx_start  output  1  one-cycle TX start strobe.
- o_state  output  3  current FSM state encoding, for debug.

Behaviour:
- Reset (basys_reset=0, asynchronous): state IDLE; all outputs 0; word/byte counters 0; any partial word discarded. Applies mid-load or mid-run.
- All outputs are registered.
- State encodings: IDLE=0, LOAD_CNT=1, LOAD_BYTE=2, LOAD_WRITE=3, RUN=4, STEP=5, HALTED=6, DUMP=7.
- IDLE: on i_rx_done, decode i_rx_data:
  - 0x4C 'L' -> LOAD_CNT.
  - 0x43 'C' -> RUN.
  - 0x53 'S' -> STEP.
  - 0x52 'R' -> o_cpu_rst=1 for exactly one cycle; stay IDLE.
  - Any other byte is ignored.
- LOAD_CNT: next byte is the word count N.
  - N=0 -> IDLE, no writes.
  - N>CELDAS_M -> clamp to CELDAS_M.
  - Word index reset to 0; -> LOAD_BYTE.
- LOAD_BYTE: bytes are assembled little-endian; the first byte received lands in bits [7:0].
  - After the 4th byte -> LOAD_WRITE.
- LOAD_WRITE: one cycle with o_im_wr_en=1, o_im_addr=word index, o_im_wr_data=assembled word.
  - Word index increments.
  - If index==N after the increment -> IDLE, with o_cpu_rst=1 in the cycle after the last write. Otherwise -> LOAD_BYTE.
- o_cpu_en=0 throughout LOAD_*.
- RUN: o_cpu_en=1 every cycle.
  - i_cpu_halt=1 sampled -> HALTED, with o_cpu_en=0 from the next cycle.
  - Byte 0x50 'P' -> IDLE (pause), o_cpu_en=0 next cycle.
  - Other bytes ignored.
  - If i_cpu_halt and i_rx_done occur in the same cycle, halt wins and the byte is dropped.
- STEP: o_cpu_en=1 for exactly one cycle. Next state is HALTED if i_cpu_halt, else IDLE.
- HALTED: o_cpu_en=0.
  - 'R' -> o_cpu_rst pulse, then IDLE.
  - 'L' -> LOAD_CNT.
  - All else ignored.
- o_cpu_rst is never asserted together with o_cpu_en.
- o_im_wr_en is only ever high in LOAD_WRITE.

Optional Feature:
- Macro: DBG_DUMP_EN.
- Defined: on entry to HALTED, FSM goes to DUMP first.
  - i_cpu_pc is captured in the cycle halt is detected.
  - The 4 captured bytes are sent LSB first. Each byte: o_tx_data set, o_tx_start pulsed one cycle, then wait for i_tx_done before the next.
  - After the 4th i_tx_done -> HALTED.
  - rx bytes are ignored during DUMP.
- Not defined: DUMP state is unreachable; o_tx_data=0 and o_tx_start=0 permanently.

Test Plan:
- Load: bytes 0x4C, 0x02, 0x78 0x56 0x34 0x12, 0xEF 0xBE 0xAD 0xDE -> two o_im_wr_en pulses: addr 0 data 0x12345678, addr 1 data 0xDEADBEEF; one o_cpu_rst pulse after; state back to IDLE.
- Count edge cases: 'L' then 0x00 -> no writes, IDLE. 'L' then 0xFF -> exactly 70 writes after 280 data bytes, addresses 0..69.
- Run/halt: 'C', raise i_cpu_halt after 10 cycles -> o_cpu_en high exactly 10 cycles then 0, o_state=6. Repeat with a simultaneous 'P' strobe on the halt cycle -> halt wins, state HALTED.
- Step: 'S' three times from IDLE -> three single-cycle o_cpu_en pulses, IDLE between them.
- Reset mid-load: assert basys_reset low after 2 data bytes -> all outputs 0 asynchronously. A subsequent full load of 1 word writes addr 0 with the new word only, with no residue from the partial word.
- DBG_DUMP_EN: halt with i_cpu_pc=0x00000024 -> tx bytes 0x24, 0x00, 0x00, 0x00, each o_tx_start waiting on the prior i_tx_done. Macro undefined -> no o_tx_start pulses.
